// File: rtl/memory_bus_bridge.sv
// Registered bridge from the CPU memory bus to a flat external memory port.
// Adds programmable wait states and a ready timeout that ends hung accesses with a bus error.
module memory_bus_bridge #(
  parameter int ADDRESS_SIZE   = 15,
  parameter int DATA_WIDTH     = 32,
  parameter int WAIT_STATES    = 0,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_SIZE-1:0] cpuAddress,
  input  logic                    cpuStrobe,
  input  logic                    cpuWriteEnable,
  input  logic [DATA_WIDTH-1:0]   cpuWriteData,
  output logic [DATA_WIDTH-1:0]   cpuReadData,
  output logic                    cpuReady,
  output logic                    busError,
  output logic [ADDRESS_SIZE-1:0] memAddress,
  output logic                    memStrobe,
  output logic                    memWriteEnable,
  output logic [DATA_WIDTH-1:0]   memWriteData,
  input  logic [DATA_WIDTH-1:0]   memReadData,
  input  logic                    memReady,
  output logic [COUNT_WIDTH-1:0]  transactionCount
);

  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  state_t                 state;
  logic [7:0]             waitCount;
  logic [TIMER_WIDTH-1:0] timeoutCount;
  logic                   timeoutHit;

  // A zero TIMEOUT_CYCLES disables the limit; the timer then free-runs harmlessly.
  always_comb begin
    timeoutHit = (TIMEOUT_CYCLES > 0) &&
                 (timeoutCount == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      waitCount        <= '0;
      timeoutCount     <= '0;
      memAddress       <= '0;
      memStrobe        <= 1'b0;
      memWriteEnable   <= 1'b0;
      memWriteData     <= '0;
      cpuReadData      <= '0;
      cpuReady         <= 1'b0;
      busError         <= 1'b0;
      transactionCount <= '0;
    end else begin
      cpuReady <= 1'b0;
      busError <= 1'b0;
      case (state)
        IDLE: begin
          if (cpuStrobe) begin
            memAddress     <= cpuAddress;
            memWriteEnable <= cpuWriteEnable;
            memWriteData   <= cpuWriteData;
            timeoutCount   <= '0;
            if (WAIT_STATES > 0) begin
              state     <= WAIT;
              waitCount <= 8'(WAIT_STATES - 1);
            end else begin
              state     <= ACCESS;
              memStrobe <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (waitCount == 8'd0) begin
            state     <= ACCESS;
            memStrobe <= 1'b1;
          end else begin
            waitCount <= waitCount - 8'd1;
          end
        end
        ACCESS: begin
          // memReady takes priority over a timeout expiring on the same edge.
          if (memReady || timeoutHit) begin
            state            <= DONE;
            memStrobe        <= 1'b0;
            cpuReady         <= 1'b1;
            busError         <= !memReady;
            transactionCount <= transactionCount + 1'b1;
            if (!memReady) begin
              cpuReadData <= '1;
            end else if (!memWriteEnable) begin
              cpuReadData <= memReadData;
            end
          end else begin
            timeoutCount <= timeoutCount + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_bridge.sv
// Randomised self-checking bench for memory_bus_bridge: two instances (0 and 3 wait states)
// driven against a transaction-level model of latency, data, error and counter behaviour.
module tb_memory_bus_bridge;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int NEVER = 1000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          cpuStrobe      [2];
  logic          cpuWriteEnable [2];
  logic [AW-1:0] cpuAddress     [2];
  logic [DW-1:0] cpuWriteData   [2];
  logic [DW-1:0] cpuReadData    [2];
  logic          cpuReady       [2];
  logic          busError       [2];
  logic [AW-1:0] memAddress     [2];
  logic          memStrobe      [2];
  logic          memWriteEnable [2];
  logic [DW-1:0] memWriteData   [2];
  logic [DW-1:0] memReadData    [2];
  logic          memReady       [2];
  logic [3:0]    count0;
  logic [15:0]   count1;

  memory_bus_bridge #(
    .ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .WAIT_STATES(0),
    .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(4)
  ) dut0 (
    .clock(clock), .reset(reset),
    .cpuAddress(cpuAddress[0]), .cpuStrobe(cpuStrobe[0]),
    .cpuWriteEnable(cpuWriteEnable[0]), .cpuWriteData(cpuWriteData[0]),
    .cpuReadData(cpuReadData[0]), .cpuReady(cpuReady[0]), .busError(busError[0]),
    .memAddress(memAddress[0]), .memStrobe(memStrobe[0]),
    .memWriteEnable(memWriteEnable[0]), .memWriteData(memWriteData[0]),
    .memReadData(memReadData[0]), .memReady(memReady[0]),
    .transactionCount(count0)
  );

  memory_bus_bridge #(
    .ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .WAIT_STATES(3),
    .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(16)
  ) dut1 (
    .clock(clock), .reset(reset),
    .cpuAddress(cpuAddress[1]), .cpuStrobe(cpuStrobe[1]),
    .cpuWriteEnable(cpuWriteEnable[1]), .cpuWriteData(cpuWriteData[1]),
    .cpuReadData(cpuReadData[1]), .cpuReady(cpuReady[1]), .busError(busError[1]),
    .memAddress(memAddress[1]), .memStrobe(memStrobe[1]),
    .memWriteEnable(memWriteEnable[1]), .memWriteData(memWriteData[1]),
    .memReadData(memReadData[1]), .memReady(memReady[1]),
    .transactionCount(count1)
  );

  int numChecks = 0;
  int numPassed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got === exp) numPassed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // External memory model: written words live in the map, others follow a fixed hash.
  logic [31:0] memModel [int];
  int readyDelay [2];
  int runLen     [2] = '{0, 0};
  int strobeTotal[2] = '{0, 0};

  function automatic logic [31:0] memRead(input int a);
    if (memModel.exists(a)) return memModel[a];
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // Responder: answers after readyDelay strobe cycles, and toggles memReady randomly while idle.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (memStrobe[i]) begin
        memReady[i]    = (runLen[i] == readyDelay[i]);
        memReadData[i] = memReady[i] ? memRead(int'(memAddress[i])) : $urandom;
        if (memReady[i] && memWriteEnable[i]) memModel[int'(memAddress[i])] = memWriteData[i];
        runLen[i]++;
        strobeTotal[i]++;
      end else begin
        runLen[i]      = 0;
        memReady[i]    = 1'($urandom);
        memReadData[i] = $urandom;
      end
    end
  end

  logic [31:0] expRead [2];
  int          expCount[2];

  function automatic int waitStates(input int idx);
    return (idx == 0) ? 0 : 3;
  endfunction

  function automatic int countMask(input int idx);
    return (idx == 0) ? 32'hF : 32'hFFFF;
  endfunction

  function automatic logic [31:0] getCount(input int idx);
    return (idx == 0) ? {28'd0, count0} : {16'd0, count1};
  endfunction

  function automatic int pickDelay();
    case ($urandom_range(0, 9))
      6:       return 14;
      7:       return 15;
      8:       return 16;
      9:       return NEVER;
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  // One transaction, starting and ending with the DUT in IDLE at the sample point.
  task automatic runTxn(input int idx, input logic we, input int addr,
                        input logic [31:0] data, input int delay);
    int n, firstStrobe, s0, ws, expReady, expStrobe;
    bit timedOut;
    logic [31:0] expData;
    ws        = waitStates(idx);
    timedOut  = (delay >= TO);
    expReady  = timedOut ? ws + TO : ws + 1 + delay;
    expStrobe = timedOut ? TO : delay + 1;
    expData   = timedOut ? 32'hFFFF_FFFF : (we ? expRead[idx] : memRead(addr));
    readyDelay[idx] = delay;
    s0 = strobeTotal[idx];
    cpuStrobe[idx]      = 1'b1;
    cpuWriteEnable[idx] = we;
    cpuAddress[idx]     = AW'(addr);
    cpuWriteData[idx]   = data;
    @(posedge clock); #2;
    // The accepted request must be immune to later changes on the CPU side.
    cpuStrobe[idx]      = 1'b0;
    cpuWriteEnable[idx] = 1'($urandom);
    cpuAddress[idx]     = AW'($urandom);
    cpuWriteData[idx]   = $urandom;
    n = 0;
    firstStrobe = -1;
    while (!cpuReady[idx] && n < 100) begin
      if (memStrobe[idx] && firstStrobe < 0) begin
        firstStrobe = n;
        check("mem_address", 32'(memAddress[idx]), 32'(AW'(addr)));
        check("mem_write_enable", 32'(memWriteEnable[idx]), 32'(we));
        check("mem_write_data", memWriteData[idx], data);
      end
      @(posedge clock); #2;
      n++;
    end
    check("ready_seen", 32'(cpuReady[idx]), 32'd1);
    check("ready_latency", n, expReady);
    check("strobe_rise", firstStrobe, ws);
    check("strobe_length", strobeTotal[idx] - s0, expStrobe);
    check("bus_error", 32'(busError[idx]), 32'(timedOut));
    check("read_data", cpuReadData[idx], expData);
    expRead[idx]  = expData;
    expCount[idx] = (expCount[idx] + 1) & countMask(idx);
    check("count", getCount(idx), expCount[idx]);
    @(posedge clock); #2;
    check("ready_pulse_width", 32'(cpuReady[idx]), 32'd0);
    check("error_pulse_width", 32'(busError[idx]), 32'd0);
  endtask

  // Strobe held across two reads: the second is taken in the IDLE cycle after DONE,
  // leaving a gap of WAIT_STATES+2 low cycles between the two cpuReady pulses.
  task automatic backToBack(input int idx, input int addr);
    int n, r1, r2, ws;
    logic [31:0] expData;
    ws = waitStates(idx);
    expData = memRead(addr);
    readyDelay[idx]     = 0;
    cpuStrobe[idx]      = 1'b1;
    cpuWriteEnable[idx] = 1'b0;
    cpuAddress[idx]     = AW'(addr);
    @(posedge clock); #2;
    n = 0; r1 = -1; r2 = -1;
    while (r2 < 0 && n < 100) begin
      if (cpuReady[idx]) begin
        if (r1 < 0) r1 = n;
        else r2 = n;
        check("b2b_data", cpuReadData[idx], expData);
      end
      if (r2 < 0) begin
        @(posedge clock); #2;
        n++;
      end
    end
    cpuStrobe[idx] = 1'b0;
    check("b2b_first", r1, ws + 1);
    check("b2b_spacing", r2 - r1, ws + 3);
    expRead[idx]  = expData;
    expCount[idx] = (expCount[idx] + 2) & countMask(idx);
    check("b2b_count", getCount(idx), expCount[idx]);
    repeat (2) begin
      @(posedge clock); #2;
    end
    check("b2b_no_third", 32'(cpuReady[idx] | memStrobe[idx]), 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_strobe"}, 32'(memStrobe[i]), 32'd0);
      check({tag, "_ready"}, 32'(cpuReady[i] | busError[i]), 32'd0);
      check({tag, "_count"}, getCount(i), 32'd0);
      check({tag, "_rdata"}, cpuReadData[i], 32'd0);
      check({tag, "_maddr"}, 32'(memAddress[i]) | memWriteData[i], 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cpuStrobe[i] = 1'b0; cpuWriteEnable[i] = 1'b0;
      cpuAddress[i] = '0;  cpuWriteData[i] = '0;
      readyDelay[i] = NEVER; expRead[i] = '0; expCount[i] = 0;
    end
    repeat (3) @(posedge clock);
    #2;
    checkResetState("reset");
    reset = 1'b0;
    @(posedge clock); #2;

    runTxn(0, 1'b0, 'h2000, 32'h0, 0);
    runTxn(1, 1'b1, 'h0010, 32'h1234_5678, 0);
    runTxn(1, 1'b0, 'h0010, 32'h0, 0);
    runTxn(0, 1'b0, 'h0005, 32'h0, NEVER);
    runTxn(0, 1'b0, 'h0006, 32'h0, TO - 1);
    runTxn(1, 1'b1, 'h0007, 32'hCAFE_F00D, TO);
    backToBack(0, 'h0009);
    backToBack(1, 'h000A);

    for (int k = 0; k < 60; k++) begin
      runTxn(int'($urandom_range(0, 1)), 1'($urandom), int'($urandom_range(0, 31)),
             $urandom, pickDelay());
    end

    // Asynchronous reset in the middle of an access, away from any clock edge.
    readyDelay[1] = NEVER;
    cpuStrobe[1] = 1'b1; cpuWriteEnable[1] = 1'b0; cpuAddress[1] = AW'(3);
    @(posedge clock); #2;
    cpuStrobe[1] = 1'b0;
    repeat (6) begin
      @(posedge clock); #2;
    end
    check("pre_reset_strobe", 32'(memStrobe[1]), 32'd1);
    reset = 1'b1;
    #1;
    checkResetState("async_reset");
    for (int i = 0; i < 2; i++) begin
      expRead[i] = '0; expCount[i] = 0;
    end
    @(posedge clock); #2;
    reset = 1'b0;
    @(posedge clock); #2;
    runTxn(1, 1'b0, 'h0003, 32'h0, 1);

    // 17 completions on a 4-bit counter wrap to 1.
    for (int k = 0; k < 17; k++) begin
      runTxn(0, 1'($urandom), int'($urandom_range(0, 31)), $urandom, pickDelay());
    end
    check("count_wrap", getCount(0), 32'd1);

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
